inst_fetch: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of the instruction ROM. It drives the 8-bit `InstAddress` each cycle and sequences execution from a `Start` pulse to a `Halt` indication. It applies absolute branch redirects and stalls, and counts retired fetches for performance readout. `InstAddress` is registered and the ROM is combinational, so the instruction for the current PC is valid in the same cycle.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sat_counter.sv | 36 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and widths for the CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_RUN    = 2'd1,
        F_HALTED = 2'd2
    } fetch_state_t;

    localparam int PC_W   = 8;
    localparam int INST_W = 9;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_value;

    // Clear outranks enable so a restart always begins from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (enable && (r_value != c_MAX)) begin
            r_value <= r_value + c_ONE;
        end
    end

    assign value = r_value;

endmodule : sat_counter
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Program counter and fetch sequencing (IDLE / RUN / HALTED) with
//            branch redirect, stall and a saturating fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [PC_W-1:0]  BranchTarget,
    output logic [PC_W-1:0]  InstAddress,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] FetchCount
);

    import cpu_pkg::*;

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic            r_running;
    logic            r_done;
    logic            w_cnt_clear;
    logic            w_cnt_en;

    // State, PC and status flags; flags are derived from next state so they
    // line up with the state they describe without a combinational output path.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= F_IDLE;
            r_pc      <= START_ADDR;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_running <= (w_state_next == F_RUN);
            r_done    <= (w_state_next == F_HALTED);
        end
    end

    // Next-state and next-PC priority mux: Start > Halt > Stall > Branch > +1.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            F_IDLE, F_HALTED: begin
                if (Start) begin
                    w_state_next = F_RUN;
                    w_pc_next    = START_ADDR;
                    w_cnt_clear  = 1'b1;
                end
            end
            F_RUN: begin
                if (Start) begin
                    w_pc_next   = START_ADDR;
                    w_cnt_clear = 1'b1;
                end else if (Halt) begin
                    w_state_next = F_HALTED;
                end else if (Stall) begin
                    w_pc_next = r_pc;
                end else if (BranchTaken) begin
                    w_pc_next = BranchTarget;
                    w_cnt_en  = 1'b1;
                end else begin
                    w_pc_next = r_pc + c_PC_ONE;
                    w_cnt_en  = 1'b1;
                end
            end
            default: begin
                w_state_next = F_IDLE;
                w_pc_next    = START_ADDR;
            end
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_fetch_cnt (
        .clk    (CLK),
        .rst    (reset),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .value  (FetchCount)
    );

    assign InstAddress = r_pc;
    assign Running     = r_running;
    assign Done        = r_done;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Scoreboard bench for inst_fetch; a second instance with a 4-bit
//            counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    typedef struct {
        logic [7:0] pc;
        logic       run;
        logic       done;
        int         cnt16;
        int         cnt4;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_reset, r_start, r_halt, r_stall, r_br;
    logic [7:0]  r_tgt;
    logic [7:0]  w_addr, w_addr4;
    logic        w_run, w_run4, w_done, w_done4;
    logic [15:0] w_cnt;
    logic [3:0]  w_cnt4;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state
    int          m_state = 0;
    logic [7:0]  m_pc    = 8'd0;
    int          m_cnt   = 0;

    always #5 clk = ~clk;

    inst_fetch #(.PC_W(8), .START_ADDR(8'd0), .CNT_W(16)) dut (
        .CLK(clk), .reset(r_reset), .Start(r_start), .Halt(r_halt),
        .Stall(r_stall), .BranchTaken(r_br), .BranchTarget(r_tgt),
        .InstAddress(w_addr), .Running(w_run), .Done(w_done),
        .FetchCount(w_cnt)
    );

    inst_fetch #(.PC_W(8), .START_ADDR(8'd0), .CNT_W(4)) dut4 (
        .CLK(clk), .reset(r_reset), .Start(r_start), .Halt(r_halt),
        .Stall(r_stall), .BranchTaken(r_br), .BranchTarget(r_tgt),
        .InstAddress(w_addr4), .Running(w_run4), .Done(w_done4),
        .FetchCount(w_cnt4)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("InstAddress", int'(w_addr), int'(e.pc));
            chk("Running", int'(w_run), int'(e.run));
            chk("Done", int'(w_done), int'(e.done));
            chk("FetchCount", int'(w_cnt), e.cnt16);
            chk("FetchCount4", int'(w_cnt4), e.cnt4);
            chk("InstAddress4", int'(w_addr4), int'(e.pc));
            chk("Running4", int'(w_run4), int'(e.run));
            chk("Done4", int'(w_done4), int'(e.done));
        end
    end

    // Drive one cycle, advance the model at the edge and queue its outputs.
    task automatic step(input logic rs, input logic st, input logic h,
                        input logic s, input logic b, input logic [7:0] t);
        exp_t e;
        r_reset = rs; r_start = st; r_halt = h; r_stall = s; r_br = b; r_tgt = t;
        @(posedge clk);
        if (rs) begin
            m_state = 0; m_pc = 8'd0; m_cnt = 0;
        end else if (m_state == 0 || m_state == 2) begin
            if (st) begin m_state = 1; m_pc = 8'd0; m_cnt = 0; end
        end else begin
            if (st)      begin m_pc = 8'd0; m_cnt = 0; end
            else if (h)  m_state = 2;
            else if (s)  ;
            else if (b)  begin m_pc = t; m_cnt++; end
            else         begin m_pc = m_pc + 8'd1; m_cnt++; end
        end
        e.pc    = m_pc;
        e.run   = (m_state == 1);
        e.done  = (m_state == 2);
        e.cnt16 = (m_cnt > 65535) ? 65535 : m_cnt;
        e.cnt4  = (m_cnt > 15) ? 15 : m_cnt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        r_reset = 1'b1; r_start = 1'b0; r_halt = 1'b0;
        r_stall = 1'b0; r_br = 1'b0; r_tgt = 8'd0;
        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        // IDLE ignores branch, stall and halt
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd45);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        // Start, straight-line 0,1,2,3
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) idle_cycle();
        // branch to 11, then branch+stall holds, then branch to 45
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd45);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd45);
        // halt+stall: halt wins
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        // go to 75 then halt together with a branch
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd75);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd99);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd12);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        idle_cycle();
        // restart from HALTED
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        // 20 advances: 4-bit counter saturates at 15
        repeat (20) idle_cycle();
        // wrap 255 -> 0
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd253);
        repeat (5) idle_cycle();
        // Start together with Halt: Start wins
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        idle_cycle();
        // reset mid-RUN at PC 30 with a pending branch
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd30);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd77);
        idle_cycle();
        idle_cycle();
        // drain the scoreboard within a bounded number of cycles
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
